// File: rtl/sram_stream_loader.sv
// -----------------------------------------------------------------------------
// sram_stream_loader
//
// Loads a fixed-length run of words from a valid/ready stream into one of two
// SRAM write ports: feature SRAM (cfg_target = 0) or kernel SRAM
// (cfg_target = 1). Words are written at consecutive word-aligned byte
// addresses starting at cfg_baseaddr with the two low bits cleared. The address
// advances by 4 per word and wraps silently at 2^ADDR_WIDTH.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   cfg_start           : one-cycle start request, honoured only in IDLE
//   cfg_target          : destination select (0 = fram, 1 = kram)
//   cfg_baseaddr        : byte start address
//   cfg_len             : number of words to load (0 = finish immediately)
//   busy, done, err     : transfer active, completion pulse, sticky framing error
//   words_written       : words written in the current or last transfer
//   s_axis_*            : input stream (tdata, tvalid, tlast, tready)
//   fram_* / kram_*     : SRAM write ports (byte address, data, we, en)
//
// Every output is driven from a flop. A write strobe appears on the cycle after
// its beat is accepted.
// -----------------------------------------------------------------------------
module sram_stream_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_target,
  input  logic [ADDR_WIDTH-1:0] cfg_baseaddr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_written,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] fram_addr_byteidx,
  output logic [DATA_WIDTH-1:0] fram_wdata,
  output logic                  fram_we,
  output logic                  fram_en,
  output logic [ADDR_WIDTH-1:0] kram_addr_byteidx,
  output logic [DATA_WIDTH-1:0] kram_wdata,
  output logic                  kram_we,
  output logic                  kram_en
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                state_q;
  logic                  target_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  ww_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  tready_q;
  logic [ADDR_WIDTH-1:0] fram_addr_q;
  logic [DATA_WIDTH-1:0] fram_wdata_q;
  logic                  fram_wr_q;
  logic [ADDR_WIDTH-1:0] kram_addr_q;
  logic [DATA_WIDTH-1:0] kram_wdata_q;
  logic                  kram_wr_q;

  logic                  accept_d;
  logic [LEN_WIDTH-1:0]  ww_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  final_d;
  logic                  end_d;
  logic                  err_d;

  // Beat handshake and the next values of the word counter and address.
  always_comb begin
    accept_d = s_axis_tvalid & tready_q;
    ww_d     = ww_q + LEN_WIDTH'(1);
    addr_d   = addr_q + ADDR_WIDTH'(4);
    final_d  = (ww_d == len_q);
    // The transfer ends on the word that completes len, or earlier on tlast.
    end_d    = final_d | s_axis_tlast;
    // Framing is good only when tlast lands exactly on the final word.
    if (final_d) begin
      err_d = ~s_axis_tlast;
    end else begin
      err_d = 1'b1;
    end
  end

  // Transfer FSM together with all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      target_q     <= 1'b0;
      len_q        <= '0;
      ww_q         <= '0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tready_q     <= 1'b0;
      fram_addr_q  <= '0;
      fram_wdata_q <= '0;
      fram_wr_q    <= 1'b0;
      kram_addr_q  <= '0;
      kram_wdata_q <= '0;
      kram_wr_q    <= 1'b0;
    end else begin
      // Strobes and done are single-cycle unless reasserted below.
      fram_wr_q <= 1'b0;
      kram_wr_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q   <= 1'b0;
          tready_q <= 1'b0;
          if (cfg_start) begin
            target_q <= cfg_target;
            len_q    <= cfg_len;
            addr_q   <= cfg_baseaddr & ~ADDR_WIDTH'(3);
            err_q    <= 1'b0;
            ww_q     <= '0;
            busy_q   <= 1'b1;
            if (cfg_len == LEN_WIDTH'(0)) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q  <= LOAD;
              tready_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          if (accept_d) begin
            if (target_q) begin
              kram_addr_q  <= addr_q;
              kram_wdata_q <= s_axis_tdata;
              kram_wr_q    <= 1'b1;
            end else begin
              fram_addr_q  <= addr_q;
              fram_wdata_q <= s_axis_tdata;
              fram_wr_q    <= 1'b1;
            end
            addr_q <= addr_d;
            ww_q   <= ww_d;
            if (end_d) begin
              state_q  <= FINISH;
              done_q   <= 1'b1;
              tready_q <= 1'b0;
              err_q    <= err_q | err_d;
            end else begin
              state_q <= LOAD;
            end
          end else begin
            state_q <= LOAD;
          end
        end
        FINISH: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          tready_q <= 1'b0;
        end
        default: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign words_written     = ww_q;
  assign s_axis_tready     = tready_q;
  assign fram_addr_byteidx = fram_addr_q;
  assign fram_wdata        = fram_wdata_q;
  assign fram_we           = fram_wr_q;
  assign fram_en           = fram_wr_q;
  assign kram_addr_byteidx = kram_addr_q;
  assign kram_wdata        = kram_wdata_q;
  assign kram_we           = kram_wr_q;
  assign kram_en           = kram_wr_q;

endmodule

// File: doc/sram_stream_loader.md
SRAM_STREAM_LOADER -- requirements
Module: sram_stream_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: stream and SRAM word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16: byte-indexed SRAM address width.
REQ-003 Parameter LEN_WIDTH, default 16: transfer length width, in words.
REQ-004 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port cfg_start, input, 1: single-cycle start request.
REQ-007 Port cfg_target, input, 1: destination select, 0 = feature SRAM, 1 = kernel SRAM.
REQ-008 Port cfg_baseaddr, input, ADDR_WIDTH: byte start address.
REQ-009 Port cfg_len, input, LEN_WIDTH: number of words to load.
REQ-010 Port busy, output, 1: high while a transfer is active.
REQ-011 Port done, output, 1: one-cycle completion pulse.
REQ-012 Port err, output, 1: sticky framing error flag.
REQ-013 Port words_written, output, LEN_WIDTH: count of words written in the current or last transfer.
REQ-014 Port s_axis_tdata, input, DATA_WIDTH: stream data.
REQ-015 Port s_axis_tvalid, input, 1: stream valid.
REQ-016 Port s_axis_tlast, input, 1: stream last.
REQ-017 Port s_axis_tready, output, 1: stream ready.
REQ-018 Ports fram_addr_byteidx (output, ADDR_WIDTH), fram_wdata (output, DATA_WIDTH), fram_we (output, 1), fram_en (output, 1): feature SRAM write port.
REQ-019 Ports kram_addr_byteidx (output, ADDR_WIDTH), kram_wdata (output, DATA_WIDTH), kram_we (output, 1), kram_en (output, 1): kernel SRAM write port.

Function
REQ-020 The FSM SHALL have three states: IDLE, LOAD, FINISH.
REQ-021 In IDLE, cfg_start SHALL latch target, len and baseaddr with bits [1:0] forced to 0, clear err and words_written, and move to LOAD, or to FINISH if cfg_len == 0.
REQ-022 cfg_start SHALL be ignored in LOAD and FINISH.
REQ-023 busy SHALL be 1 in LOAD and FINISH and 0 in IDLE.
REQ-024 s_axis_tready SHALL be 1 only in LOAD and 0 in all other states.
REQ-025 A beat is accepted when tvalid & tready.
REQ-026 An accepted beat SHALL produce, on the next cycle, exactly one write on the selected port: en = 1, we = 1, addr = current address, wdata = tdata.
REQ-027 SRAM outputs SHALL be registered, giving a write latency of 1 cycle from acceptance.
REQ-028 The unselected port SHALL hold en = 0 and we = 0 throughout.
REQ-029 The address SHALL increment by 4 per accepted beat, modulo 2^ADDR_WIDTH; wrap-around is silent.
REQ-030 words_written SHALL increment in the same cycle as each write strobe.
REQ-031 When the beat completing cfg_len words is accepted, LOAD SHALL move to FINISH.
REQ-032 If that final beat has tlast = 0, err SHALL be set to 1.
REQ-033 An accepted beat with tlast = 1 before the final word SHALL be written, set err = 1, and move to FINISH; the remaining words SHALL NOT be written.
REQ-034 FINISH SHALL last exactly one cycle, coincident with the last write strobe, or the cycle after start when len = 0.
REQ-035 During FINISH, done SHALL be 1; the FSM then returns to IDLE.
REQ-036 Stalls (tvalid = 0) SHALL produce no write and no address change, with no timeout.
REQ-037 err SHALL hold until the next accepted cfg_start.
REQ-038 Back-to-back beats SHALL sustain 1 word per cycle.

Reset
REQ-039 While rst_n = 0, all outputs SHALL be 0, state SHALL be IDLE, and all counters and latched config SHALL be 0.
REQ-040 Reset asserted mid-transfer SHALL abort immediately with no further writes, no done pulse, and tready = 0.
REQ-041 After rst_n deasserts, the block SHALL wait for a fresh cfg_start.

Verification
REQ-042 Start, target = 0, base = 0x0010, len = 4; 4 back-to-back beats 0xA0..0xA3, tlast on the 4th -> fram writes at 0x10, 0x14, 0x18, 0x1C on the cycles after each accept; done pulses with the 4th write; err = 0; words_written = 4; kram_en stays 0.
REQ-043 Target = 1, base = 0x0003, len = 3; tvalid toggles 1,0,1,0,1 -> kram writes at 0x0, 0x4, 0x8 only after valid beats; done asserted 1 cycle after the 3rd accept.
REQ-044 len = 5, tlast on the 2nd beat -> 2 writes, done, err = 1, tready = 0 afterward; err clears on the next start.
REQ-045 len = 2, no tlast on the 2nd beat -> 2 writes, done = 1, err = 1.
REQ-046 ADDR_WIDTH = 16, base = 0xFFFC, len = 2 -> writes at 0xFFFC, then 0x0000.
REQ-047 len = 0 -> done 1 cycle after start, no writes; rst_n pulsed low after the 2nd beat of a len = 8 transfer -> all outputs 0 immediately, no done pulse.
